// File: rtl/condlogic_it_if.sv
// Control/flag bus between the decode stage and the conditional-execution unit.
// Widths are derived from the bank count and the maximum IT block length.
interface condlogic_it_if #(
    parameter int NBANK = 4,
    parameter int ITMAX = 4
);
    localparam int BANK_W = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int CNT_W  = $clog2(ITMAX + 1);

    logic              stall;
    logic              flush;
    logic [3:0]        Cond;
    logic [3:0]        ALUFlags;
    logic [3:0]        FlagsE;
    logic              FlagSel;
    logic [1:0]        FlagW;
    logic [BANK_W-1:0] RdBank;
    logic [BANK_W-1:0] WrBank;
    logic              PCS;
    logic              Branch;
    logic              RegW;
    logic              MemW;
    logic              ITStart;
    logic [3:0]        ITCond;
    logic [CNT_W-1:0]  ITLen;
    logic [ITMAX-1:0]  ITMask;
    logic              PCSrc;
    logic              RegWrite;
    logic              MemWrite;
    logic [3:0]        FlagsN;
    logic              CondEx;
    logic              InIT;
    logic              ITErr;

    modport master (
        output stall, flush, Cond, ALUFlags, FlagsE, FlagSel, FlagW, RdBank, WrBank,
               PCS, Branch, RegW, MemW, ITStart, ITCond, ITLen, ITMask,
        input  PCSrc, RegWrite, MemWrite, FlagsN, CondEx, InIT, ITErr
    );

    modport slave (
        input  stall, flush, Cond, ALUFlags, FlagsE, FlagSel, FlagW, RdBank, WrBank,
               PCS, Branch, RegW, MemW, ITStart, ITCond, ITLen, ITMask,
        output PCSrc, RegWrite, MemWrite, FlagsN, CondEx, InIT, ITErr
    );
endinterface

// File: rtl/condlogic_it.sv
// Conditional-execution unit: banked NZCV flags, ARM condition evaluation,
// If-Then block predication, registered PCSrc/RegWrite/MemWrite.
module condlogic_it #(
    parameter int NBANK = 4,
    parameter int ITMAX = 4
) (
    input logic           clk,
    input logic           reset,
    condlogic_it_if.slave bus
);
    localparam int BANK_W = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int CNT_W  = $clog2(ITMAX + 1);
    localparam int PTR_W  = (ITMAX > 1) ? $clog2(ITMAX) : 1;
    localparam logic [3:0] COND_AL = 4'b1110;

    typedef enum logic {IDLE, ACTIVE} it_state_t;

    it_state_t        state_q, state_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [3:0]       itcond_q, itcond_d;
    logic [ITMAX-1:0] itmask_q, itmask_d;
    logic [3:0]       banks_q [NBANK];

    logic [3:0] rd_flags;
    logic [3:0] eff_cond;
    logic [3:0] wr_data;
    logic       cond_ok;
    logic       it_instr;
    logic       it_nop;
    logic       effect;
    logic       pcsrc_q, regwrite_q, memwrite_q, iterr_q;

    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, r;
        {n, z, cy, v} = f;
        case (c)
            4'b0000: r = z;
            4'b0001: r = ~z;
            4'b0010: r = cy;
            4'b0011: r = ~cy;
            4'b0100: r = n;
            4'b0101: r = ~n;
            4'b0110: r = v;
            4'b0111: r = ~v;
            4'b1000: r = cy & ~z;
            4'b1001: r = ~cy | z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = ~z & (n == v);
            4'b1101: r = z | (n != v);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    always_comb begin
        rd_flags = '0;
        for (int unsigned i = 0; i < NBANK; i++) begin
            if (BANK_W'(i) == bus.RdBank) rd_flags = banks_q[i];
        end
    end

    // Inside a block the slot's Then/Else flips the base condition's LSB; AL stays AL.
    always_comb begin
        if (state_q == ACTIVE) begin
            if (itcond_q == COND_AL) eff_cond = COND_AL;
            else eff_cond = {itcond_q[3:1], itcond_q[0] ^ ~itmask_q[ptr_q]};
        end else begin
            eff_cond = bus.Cond;
        end
    end

    assign cond_ok  = cond_eval(eff_cond, rd_flags);
    assign it_instr = bus.ITStart & (state_q == IDLE);
    assign it_nop   = bus.ITStart & (state_q == ACTIVE);
    // IT instructions and rejected nested ITs never touch flags or outputs.
    assign effect   = ~bus.stall & ~bus.flush & cond_ok & ~bus.ITStart;
    assign wr_data  = bus.FlagSel ? bus.FlagsE : bus.ALUFlags;

    assign bus.CondEx   = it_instr | cond_ok;
    assign bus.FlagsN   = rd_flags;
    assign bus.InIT     = (remain_q != '0);
    assign bus.PCSrc    = pcsrc_q;
    assign bus.RegWrite = regwrite_q;
    assign bus.MemWrite = memwrite_q;
    assign bus.ITErr    = iterr_q;

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        ptr_d    = ptr_q;
        itcond_d = itcond_q;
        itmask_d = itmask_q;
        if (bus.flush) begin
            state_d  = IDLE;
            remain_d = '0;
        end else if (!bus.stall) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.ITStart && bus.ITLen != '0) begin
                        remain_d = (bus.ITLen > CNT_W'(ITMAX)) ? CNT_W'(ITMAX) : bus.ITLen;
                        ptr_d    = '0;
                        itcond_d = bus.ITCond;
                        itmask_d = bus.ITMask | ITMAX'(1);
                        state_d  = ACTIVE;
                    end
                end
                ACTIVE: begin
                    remain_d = remain_q - CNT_W'(1);
                    ptr_d    = ptr_q + PTR_W'(1);
                    if (remain_q == CNT_W'(1)) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            remain_q <= '0;
            ptr_q    <= '0;
            itcond_q <= '0;
            itmask_q <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            ptr_q    <= ptr_d;
            itcond_q <= itcond_d;
            itmask_q <= itmask_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NBANK; i++) banks_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NBANK; i++) begin
                if (effect && BANK_W'(i) == bus.WrBank) begin
                    if (bus.FlagW[1]) banks_q[i][3:2] <= wr_data[3:2];
                    if (bus.FlagW[0]) banks_q[i][1:0] <= wr_data[1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcsrc_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memwrite_q <= 1'b0;
            iterr_q    <= 1'b0;
        end else begin
            pcsrc_q    <= (bus.PCS | bus.Branch) & effect;
            regwrite_q <= bus.RegW & effect;
            memwrite_q <= bus.MemW & effect;
            if (bus.flush) iterr_q <= 1'b0;
            else if (!bus.stall) iterr_q <= it_nop;
        end
    end
endmodule

// File: tb/tb_condlogic_it.sv
// Bench for condlogic_it: directed scenarios plus random traffic, all compared
// against a queue-based behavioural model of flags and IT slots.
module tb_condlogic_it;
    localparam int NB = 4;
    localparam int IM = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    condlogic_it_if #(.NBANK(NB), .ITMAX(IM)) bus ();

    condlogic_it #(.NBANK(NB), .ITMAX(IM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] mfl [NB];
    logic [3:0] itq [$];
    bit m_pc, m_rw, m_mw, m_ie;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit evalc(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic model_clear();
        foreach (mfl[i]) mfl[i] = '0;
        itq.delete();
        m_pc = 0; m_rw = 0; m_mw = 0; m_ie = 0;
    endtask

    task automatic clr();
        bus.stall = 0; bus.flush = 0; bus.Cond = 4'hE;
        bus.ALUFlags = '0; bus.FlagsE = '0; bus.FlagSel = 0; bus.FlagW = '0;
        bus.RdBank = '0; bus.WrBank = '0;
        bus.PCS = 0; bus.Branch = 0; bus.RegW = 0; bus.MemW = 0;
        bus.ITStart = 0; bus.ITCond = '0; bus.ITLen = '0; bus.ITMask = '0;
    endtask

    // Called at a falling edge with inputs applied; returns at the next falling edge.
    task automatic step();
        bit act, ce, acc, eff;
        logic [3:0] effc, wd;
        int n;
        #1;
        act  = (itq.size() != 0);
        effc = act ? itq[0] : bus.Cond;
        ce   = evalc(effc, mfl[bus.RdBank]);
        check("CondEx",   bus.CondEx, (bus.ITStart && !act) ? 1 : ce);
        check("FlagsN",   bus.FlagsN, mfl[bus.RdBank]);
        check("InIT",     bus.InIT, act);
        check("PCSrc",    bus.PCSrc, m_pc);
        check("RegWrite", bus.RegWrite, m_rw);
        check("MemWrite", bus.MemWrite, m_mw);
        check("ITErr",    bus.ITErr, m_ie);
        @(posedge clk);
        acc = !bus.stall && !bus.flush;
        eff = acc && ce && !bus.ITStart;
        wd  = bus.FlagSel ? bus.FlagsE : bus.ALUFlags;
        m_pc = (bus.PCS || bus.Branch) && eff;
        m_rw = bus.RegW && eff;
        m_mw = bus.MemW && eff;
        if (eff && bus.FlagW[1]) mfl[bus.WrBank][3:2] = wd[3:2];
        if (eff && bus.FlagW[0]) mfl[bus.WrBank][1:0] = wd[1:0];
        if (!(bus.stall && !bus.flush)) m_ie = acc && bus.ITStart && act;
        if (bus.flush) begin
            itq.delete();
        end else if (acc) begin
            if (act) begin
                void'(itq.pop_front());
            end else if (bus.ITStart && bus.ITLen != 0) begin
                n = (int'(bus.ITLen) > IM) ? IM : int'(bus.ITLen);
                for (int i = 0; i < n; i++) begin
                    if (i == 0 || bus.ITMask[i] || bus.ITCond == 4'hE) itq.push_back(bus.ITCond);
                    else itq.push_back(bus.ITCond ^ 4'd1);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic wflags(input int bank, input logic [3:0] f);
        clr(); bus.ALUFlags = f; bus.FlagW = 2'b11; bus.WrBank = 2'(bank); step();
    endtask

    task automatic it_go(input logic [3:0] c, input int len, input logic [3:0] mask);
        clr(); bus.ITStart = 1; bus.ITCond = c; bus.ITLen = 3'(len); bus.ITMask = mask; step();
    endtask

    task automatic slot(input bit st, input bit fl, input bit its);
        clr(); bus.Cond = 4'h1; bus.RegW = 1; bus.stall = st; bus.flush = fl; bus.ITStart = its;
        if (fl) bus.FlagW = 2'b11;
        step();
    endtask

    task automatic mid_reset();
        clr();
        #2 reset = 0;
        #1;
        check("mr_PCSrc", bus.PCSrc, 0);
        check("mr_RegWrite", bus.RegWrite, 0);
        check("mr_MemWrite", bus.MemWrite, 0);
        check("mr_ITErr", bus.ITErr, 0);
        check("mr_InIT", bus.InIT, 0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1;
    endtask

    initial begin
        model_clear();
        clr();
        repeat (2) @(negedge clk);
        check("rst_PCSrc", bus.PCSrc, 0);
        check("rst_RegWrite", bus.RegWrite, 0);
        check("rst_MemWrite", bus.MemWrite, 0);
        check("rst_ITErr", bus.ITErr, 0);
        check("rst_InIT", bus.InIT, 0);
        check("rst_FlagsN", bus.FlagsN, 0);
        reset = 1;

        clr(); bus.Cond = 4'h0; bus.RegW = 1; step();
        clr(); bus.Cond = 4'hE; bus.RegW = 1; step();
        check("eq_z0_then_al", bus.RegWrite, 1);

        wflags(2, 4'b0100);
        clr(); bus.RdBank = 2; bus.Cond = 4'h0; bus.RegW = 1; step();
        check("bank2_eq", bus.RegWrite, 1);
        clr(); bus.RdBank = 0; bus.Cond = 4'h0; bus.RegW = 1; step();
        check("bank0_eq", bus.RegWrite, 0);

        clr(); bus.FlagW = 2'b01; bus.ALUFlags = 4'hF; bus.WrBank = 1; step();
        clr(); bus.RdBank = 1; #1;
        check("cv_only_write", bus.FlagsN, 4'b0011);
        step();

        wflags(0, 4'b0100);
        it_go(4'h0, 3, 4'b0101);
        slot(0, 0, 0); check("it_s0", bus.RegWrite, 1);
        slot(0, 0, 0); check("it_s1", bus.RegWrite, 0);
        slot(0, 0, 0); check("it_s2", bus.RegWrite, 1);
        check("it_done", bus.InIT, 0);

        it_go(4'h0, 3, 4'b0101);
        slot(0, 0, 0);
        slot(1, 0, 0); check("stall_bubble", bus.RegWrite, 0); check("stall_hold", bus.InIT, 1);
        slot(0, 0, 0); check("stall_s1_else", bus.RegWrite, 0);
        slot(0, 0, 0); check("stall_s2", bus.RegWrite, 1);

        it_go(4'h0, 3, 4'b0101);
        slot(0, 0, 0);
        slot(0, 1, 0); check("flush_init", bus.InIT, 0);
        clr(); #1; check("flush_flags", bus.FlagsN, 4'b0100);
        step();

        it_go(4'h0, 3, 4'b0101);
        slot(0, 0, 0);
        slot(0, 0, 0);
        slot(0, 0, 1); check("iterr_pulse", bus.ITErr, 1);
        clr(); step(); check("iterr_clear", bus.ITErr, 0);

        wflags(0, 4'b0100);
        it_go(4'h0, 3, 4'b0111);
        slot(0, 0, 0);
        check("mr_pre_RegWrite", bus.RegWrite, 1);
        check("mr_pre_InIT", bus.InIT, 1);
        mid_reset();
        clr(); step();

        for (int k = 0; k < 1500; k++) begin
            bus.stall    = ($urandom_range(7, 0) == 0);
            bus.flush    = ($urandom_range(19, 0) == 0);
            bus.Cond     = 4'($urandom);
            bus.ALUFlags = 4'($urandom);
            bus.FlagsE   = 4'($urandom);
            bus.FlagSel  = 1'($urandom);
            bus.FlagW    = 2'($urandom);
            bus.RdBank   = 2'($urandom);
            bus.WrBank   = 2'($urandom);
            bus.PCS      = 1'($urandom);
            bus.Branch   = ($urandom_range(3, 0) == 0);
            bus.RegW     = 1'($urandom);
            bus.MemW     = 1'($urandom);
            bus.ITStart  = ($urandom_range(5, 0) == 0);
            bus.ITCond   = 4'($urandom);
            bus.ITLen    = 3'($urandom);
            bus.ITMask   = 4'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/condlogic_it.md
# condlogic_it

Parametrised conditional-execution unit for the single-issue ARM-style datapath. It holds NBANK independent NZCV flag banks with split NZ/CV write enables and evaluates the 16 ARM condition codes against a selected bank. It adds an If-Then (IT) block state machine that predicates up to ITMAX following instructions, and handles stall and flush. PCSrc, RegWrite and MemWrite are registered once before leaving the block, between decode/execute control and the writeback/PC logic.

## Interface
- NBANK, 4: number of NZCV flag banks (≥1); BANK_W = max(1, clog2(NBANK))
- ITMAX, 4: maximum IT block length (≥1); CNT_W = clog2(ITMAX+1)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hold all state; current instruction becomes a bubble
- flush  in  1  squash current instruction, clear IT state; priority over stall
- Cond  in  4  instruction condition code
- ALUFlags  in  4  {N,Z,C,V} from ALU
- FlagsE  in  4  explicit flag value (MSR-type write)
- FlagSel  in  1  0: write ALUFlags; 1: write FlagsE
- FlagW  in  2  [1]: write N,Z; [0]: write C,V
- RdBank  in  BANK_W  bank used for condition evaluation and FlagsN
- WrBank  in  BANK_W  bank written by FlagW
- PCS, Branch, RegW, MemW  in  1 each  unpredicated control from decoder
- ITStart  in  1  current instruction is an IT instruction
- ITCond  in  4  base condition of the IT block
- ITLen  in  CNT_W  block length 1..ITMAX
- ITMask  in  ITMAX  bit i: 1 = slot i Then, 0 = slot i Else
- PCSrc, RegWrite, MemWrite  out  1 each  registered predicated controls
- FlagsN  out  4  current contents of bank RdBank
- CondEx  out  1  combinational condition result for the current instruction
- InIT  out  1  IT block active (ITRemain ≠ 0)
- ITErr  out  1  registered one-cycle pulse: ITStart received inside a block

## Operation
- Condition table: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 1. Evaluated on bank RdBank.
- Effective condition: outside IT it is Cond. Inside IT slot i it is ITCond with bit0 XOR !ITMask[i], and Cond is ignored. If ITCond is AL, every slot is Then. ITMask[0] is treated as 1.
- Flag write: bank[WrBank][3:2] loads when FlagW[1]&CondEx. Bank[WrBank][1:0] loads when FlagW[0]&CondEx. Data is FlagSel ? FlagsE : ALUFlags, taking matching bit positions.
- Registered outputs load (PCS|Branch)&CondEx, RegW&CondEx and MemW&CondEx.
- IT state machine:
  - IDLE: ITRemain=0.
  - ITStart accepted in IDLE: load ITRemain=min(ITLen,ITMAX), slot pointer=0, latch ITCond/ITMask. Go to ACTIVE. ITLen=0 is ignored.
  - The IT instruction itself is unconditional, and PCS/RegW/MemW/FlagW are don't-care (outputs load 0).
  - ACTIVE: each accepted cycle consumes one slot, pointer+1, ITRemain−1. Return to IDLE when ITRemain reaches 0.
  - ITStart in ACTIVE: it is not restarted. The slot is consumed as a NOP (no flag or output effect) and ITErr pulses.
- Accepted cycle means reset high, !stall and !flush.
- Stall: banks, IT state and ITErr hold. Output registers load 0.
- Flush: output registers load 0 and no flag write occurs. IT state is cleared to IDLE. Banks are otherwise kept.
- Reset low, asynchronous: all banks 4'b0000, IDLE, PCSrc/RegWrite/MemWrite/ITErr = 0.

## Timing
- Instruction presented in cycle t:
  - CondEx valid combinationally in t.
  - Flag bank updated at the edge ending t; visible on FlagsN and to condition evaluation in t+1 (no bypass).
  - PCSrc/RegWrite/MemWrite asserted during t+1 (latency 1).
- ITStart in t: slots occupy the next min(ITLen,ITMAX) accepted cycles. Stalled cycles are not counted.
- InIT rises in t+1 and falls in the cycle after the last slot.
- Flags written by slot i condition slot i+1.
- Simultaneous WrBank==RdBank write and read: the read returns the old value.
- Reset asserted mid-cycle clears outputs immediately, without waiting for clk.

## Test plan
- Reset, then Cond=EQ, RegW=1, RdBank=0 -> RegWrite=0 (Z=0). Cond=AL -> RegWrite=1 one cycle later.
- ALUFlags=4'b0100, FlagW=2'b11, WrBank=2, Cond=AL; next cycle RdBank=2, Cond=EQ, RegW=1 -> RegWrite=1. Same with RdBank=0 -> RegWrite=0.
- FlagW=2'b01, ALUFlags=4'b1111 into a bank holding 4'b0000 -> bank=4'b0011.
- Z=1; ITStart, ITCond=EQ, ITLen=3, ITMask=3'b101; three RegW=1 instructions with Cond=NE -> RegWrite 1,0,1; InIT low afterwards.
- Same block with stall during slot 1 -> bubble with RegWrite=0, ITRemain held, slot 1 still Else when resumed. Flush in slot 1 -> InIT=0 next cycle, squashed FlagW has no effect. ITStart in slot 2 -> ITErr=1 for one cycle.
- reset pulled low between edges mid-block -> outputs 0 and InIT=0 immediately; flags 0 after release.
